// File: rtl/mmio_bridge_pkg.sv
// mmio_bridge_pkg: shared types and constants for the mmio_bridge_n slice.
//   state_e      - transaction engine states (IDLE / ISSUE / RESP)
//   PERIPH_BASE  - base of the 4 KiB peripheral window
//   ERR_DATA     - read data returned on unmapped access or timeout
//   CNT_W        - width of the optional ISSUE timeout counter
//   sel_width()  - width of the slave select field for a given slave count
package mmio_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam logic [31:0] PERIPH_BASE = 32'hFFFF_F000;
    localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;
    localparam int          CNT_W       = 8;

    // A single slave still needs a 1-bit select field.
    function automatic int sel_width(input int n_slv);
        return (n_slv > 1) ? $clog2(n_slv) : 1;
    endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// mmio_addr_decode: purely combinational address decoder.
//   addr     in  ADDR_W : byte address from the CPU
//   idx      out SEL_W  : selected slave (0 = memory / default region)
//   unmapped out 1      : peripheral-window address with no slave behind it
// Addresses outside the peripheral window always map to slave 0. Inside the
// window the select field addr[SEL_LSB +: SEL_W] picks the slave; field 0
// is reserved (memory is never reached through the peripheral window) and
// fields >= N_SLV are unpopulated.
module mmio_addr_decode
    import mmio_bridge_pkg::*;
#(
    parameter int N_SLV   = 6,
    parameter int ADDR_W  = 32,
    parameter int SEL_LSB = 5,
    parameter int SEL_W   = 3
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [SEL_W-1:0]  idx,
    output logic              unmapped
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(PERIPH_BASE);

    logic             periph_s;
    logic [SEL_W-1:0] field_s;

    // Window match and select-field extraction.
    always_comb begin
        periph_s = (addr[ADDR_W-1:12] == BASE[ADDR_W-1:12]);
        field_s  = addr[SEL_LSB +: SEL_W];
    end

    // Slave index and unmapped flag.
    always_comb begin
        if (periph_s) begin
            idx      = field_s;
            unmapped = (field_s == {SEL_W{1'b0}}) || (32'(field_s) >= 32'(N_SLV));
        end else begin
            idx      = {SEL_W{1'b0}};
            unmapped = 1'b0;
        end
    end

endmodule

// File: rtl/mmio_bridge_n.sv
// mmio_bridge_n: registered request/acknowledge bridge from the CPU to
// N_SLV memory-mapped slaves (slave 0 = memory / default region).
// Optional feature macro: MMIO_BRIDGE_TIMEOUT_EN - when defined, an ISSUE
// phase that sees no ack within TIMEOUT cycles is aborted with cpu_err=1.
// Ports:
//   cpu_clk, cpu_rst          clock, synchronous active-high reset
//   cpu_req/we/addr/wdata     CPU request (sampled in IDLE only)
//   cpu_busy                  high whenever the engine is not IDLE
//   cpu_ack/err/rdata         one-cycle completion, error flag, read data
//                             (rdata held until the next completion)
//   slv_req                   one-hot request to the selected slave
//   slv_we/addr/wdata         latched request fields, shared by all slaves
//   slv_ack, slv_rdata        per-slave acknowledge and flattened read data
// All outputs come straight from flops.
module mmio_bridge_n
    import mmio_bridge_pkg::*;
#(
    parameter int N_SLV   = 6,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_LSB = 5,
    parameter int TIMEOUT = 16
) (
    input  logic                    cpu_clk,
    input  logic                    cpu_rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic                    cpu_busy,
    output logic                    cpu_ack,
    output logic                    cpu_err,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic [N_SLV-1:0]        slv_req,
    output logic                    slv_we,
    output logic [ADDR_W-1:0]       slv_addr,
    output logic [DATA_W-1:0]       slv_wdata,
    input  logic [N_SLV-1:0]        slv_ack,
    input  logic [N_SLV*DATA_W-1:0] slv_rdata
);

    localparam int                SEL_W    = sel_width(N_SLV);
    localparam logic [N_SLV-1:0]  ONE_HOT0 = N_SLV'(1);

    // Elaboration-time guard on the timeout range.
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mmio_bridge_n: TIMEOUT must be in 2..255");
    end

    state_e             state_r;
    state_e             state_nx_s;
    logic [SEL_W-1:0]   idx_r;
    logic [SEL_W-1:0]   dec_idx_s;
    logic               dec_unmapped_s;
    logic [SEL_W-1:0]   idx_nx_s;
    logic               sel_ack_s;
    logic [DATA_W-1:0]  sel_rdata_s;
    logic [DATA_W-1:0]  rdata_arr_s [N_SLV];
    logic               expire_s;
    logic               rsp_err_s;
    logic [DATA_W-1:0]  rsp_rdata_s;

    mmio_addr_decode #(
        .N_SLV   (N_SLV),
        .ADDR_W  (ADDR_W),
        .SEL_LSB (SEL_LSB),
        .SEL_W   (SEL_W)
    ) u_decode (
        .addr     (cpu_addr),
        .idx      (dec_idx_s),
        .unmapped (dec_unmapped_s)
    );

    for (genvar gi = 0; gi < N_SLV; gi++) begin : g_rdata
        assign rdata_arr_s[gi] = slv_rdata[gi*DATA_W +: DATA_W];
    end

    // Only the latched slave's ack and data are observed.
    always_comb begin
        sel_ack_s   = slv_ack[idx_r];
        sel_rdata_s = rdata_arr_s[idx_r];
    end

`ifdef MMIO_BRIDGE_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_r;

    // Counts ISSUE cycles; cleared on entry to ISSUE.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_ISSUE) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Expiry on the TIMEOUT-th ISSUE cycle; an ack in that cycle still wins.
    always_comb begin
        expire_s = (state_r == ST_ISSUE) && (cnt_r == CNT_W'(TIMEOUT - 1));
    end
`else
    // Without the timeout option ISSUE waits for the ack indefinitely.
    always_comb begin
        expire_s = 1'b0;
    end
`endif

    // FSM state register.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_nx_s = dec_unmapped_s ? ST_RESP : ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (sel_ack_s || expire_s) begin
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            ST_RESP: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Slave index for the coming cycle and the response to capture on RESP entry.
    always_comb begin
        idx_nx_s = (state_r == ST_IDLE) ? dec_idx_s : idx_r;
        if ((state_r == ST_ISSUE) && sel_ack_s) begin
            rsp_err_s   = 1'b0;
            rsp_rdata_s = slv_we ? {DATA_W{1'b0}} : sel_rdata_s;
        end else begin
            // Unmapped address out of IDLE, or timeout out of ISSUE.
            rsp_err_s   = 1'b1;
            rsp_rdata_s = DATA_W'(ERR_DATA);
        end
    end

    // Registered outputs, driven from the next-state decision.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            slv_req   <= {N_SLV{1'b0}};
            cpu_busy  <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= {DATA_W{1'b0}};
            slv_we    <= 1'b0;
            slv_addr  <= {ADDR_W{1'b0}};
            slv_wdata <= {DATA_W{1'b0}};
            idx_r     <= {SEL_W{1'b0}};
        end else begin
            slv_req  <= (state_nx_s == ST_ISSUE) ? (ONE_HOT0 << idx_nx_s) : {N_SLV{1'b0}};
            cpu_busy <= (state_nx_s != ST_IDLE);
            cpu_ack  <= (state_nx_s == ST_RESP);
            if ((state_r == ST_IDLE) && cpu_req) begin
                slv_we    <= cpu_we;
                slv_addr  <= cpu_addr;
                slv_wdata <= cpu_wdata;
                idx_r     <= dec_idx_s;
            end
            if ((state_r != ST_RESP) && (state_nx_s == ST_RESP)) begin
                cpu_err   <= rsp_err_s;
                cpu_rdata <= rsp_rdata_s;
            end
        end
    end

endmodule

// File: tb/tb_mmio_bridge_n.sv
module tb_mmio_bridge_n;

    localparam int N_SLV   = 6;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int SEL_LSB = 5;
    localparam int TIMEOUT = 16;

    logic                    cpu_clk = 1'b0;
    logic                    cpu_rst;
    logic                    cpu_req;
    logic                    cpu_we;
    logic [ADDR_W-1:0]       cpu_addr;
    logic [DATA_W-1:0]       cpu_wdata;
    logic                    cpu_busy;
    logic                    cpu_ack;
    logic                    cpu_err;
    logic [DATA_W-1:0]       cpu_rdata;
    logic [N_SLV-1:0]        slv_req;
    logic                    slv_we;
    logic [ADDR_W-1:0]       slv_addr;
    logic [DATA_W-1:0]       slv_wdata;
    logic [N_SLV-1:0]        slv_ack;
    logic [N_SLV*DATA_W-1:0] slv_rdata;

    mmio_bridge_n #(
        .N_SLV(N_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)
    ) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .slv_req(slv_req), .slv_we(slv_we), .slv_addr(slv_addr),
        .slv_wdata(slv_wdata), .slv_ack(slv_ack), .slv_rdata(slv_rdata)
    );

    always #5 cpu_clk = ~cpu_clk;

    int cyc = 0;
    always @(posedge cpu_clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          ack_cyc;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every cpu_ack pops one expected response.
    always @(negedge cpu_clk) begin
        if (cpu_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_err"},   32'(cpu_err), 32'(e.err));
                check({e.name, "_rdata"}, cpu_rdata,    e.rdata);
                check({e.name, "_ackcyc"}, 32'(cyc),    32'(e.ack_cyc));
            end
        end
    end

    // One CPU transaction with a slave model: tgt acks in its (waits+1)-th
    // request cycle; noise (if >= 0) pulses its ack throughout ISSUE.
    task automatic do_txn(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int tgt, input int waits,
                          input int noise, input logic [31:0] rd, input logic exp_err,
                          input logic [31:0] exp_rdata, input int lat, input int exp_req);
        int   req_cnt = 0;
        bit   other = 0, fld_bad = 0, busy_bad = 0, done = 0;
        exp_t e;
        @(negedge cpu_clk);
        if (tgt >= 0) slv_rdata[tgt*DATA_W +: DATA_W] = rd;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        e.err = exp_err; e.rdata = exp_rdata; e.ack_cyc = cyc + lat; e.name = name;
        sb_q.push_back(e);
        for (int b = 0; b < 100 && !done; b++) begin
            @(negedge cpu_clk);
            cpu_req = 1'b0;
            if (cpu_ack) done = 1;
            for (int i = 0; i < N_SLV; i++) if (slv_req[i] && i != tgt) other = 1;
            if (tgt >= 0 && slv_req[tgt]) begin
                req_cnt++;
                if (!cpu_busy) busy_bad = 1;
                if (slv_we !== we || slv_addr !== addr || (we && slv_wdata !== wdata)) fld_bad = 1;
                slv_ack[tgt] = (req_cnt == waits + 1);
                if (noise >= 0) slv_ack[noise] = 1'b1;
            end else begin
                slv_ack = '0;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_noack: got no cpu_ack within 100 cycles expected one", name);
            sb_q.delete();
        end
        check({name, "_reqcycles"}, 32'(req_cnt), 32'(exp_req));
        check({name, "_otherreq"},  32'(other),   32'd0);
        check({name, "_fields"},    32'(fld_bad), 32'd0);
        check({name, "_busy"},      32'(busy_bad), 32'd0);
        @(negedge cpu_clk);
        check({name, "_heldrdata"}, cpu_rdata, exp_rdata);
        check({name, "_idle"},      32'(cpu_busy), 32'd0);
    endtask

    initial begin
        cpu_rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; slv_ack = '0; slv_rdata = '0;
        repeat (3) @(negedge cpu_clk);
        check("rst_slv_req", 32'(slv_req), 32'd0);
        check("rst_busy",    32'(cpu_busy), 32'd0);
        check("rst_ack",     32'(cpu_ack), 32'd0);
        check("rst_err",     32'(cpu_err), 32'd0);
        check("rst_rdata",   cpu_rdata, 32'd0);
        check("rst_addr",    slv_addr, 32'd0);
        cpu_rst = 1'b0;

        do_txn("rd_mem",   1'b0, 32'h0000_0040, 32'h0, 0, 0, -1, 32'h1234_5678,
               1'b0, 32'h1234_5678, 2, 1);
        do_txn("wr_s3",    1'b1, 32'hFFFF_F060, 32'hA5A5_0001, 3, 3, -1, 32'h0000_0055,
               1'b0, 32'h0000_0000, 5, 4);
        do_txn("rd_idx7",  1'b0, 32'hFFFF_F0E0, 32'h0, -1, 0, -1, 32'h0,
               1'b1, 32'hDEAD_BEEF, 1, 0);
        do_txn("rd_idx0",  1'b0, 32'hFFFF_F000, 32'h0, -1, 0, -1, 32'h0,
               1'b1, 32'hDEAD_BEEF, 1, 0);
        do_txn("rd_s5",    1'b0, 32'hFFFF_F0A0, 32'h0, 5, 1, -1, 32'hCAFE_0005,
               1'b0, 32'hCAFE_0005, 3, 2);
        do_txn("rd_s2_late", 1'b0, 32'hFFFF_F040, 32'h0, 2, 15, -1, 32'h2222_0002,
               1'b0, 32'h2222_0002, 17, 16);
`ifdef MMIO_BRIDGE_TIMEOUT_EN
        do_txn("rd_s2_tmo", 1'b0, 32'hFFFF_F040, 32'h0, 2, 1000, -1, 32'h2222_0002,
               1'b1, 32'hDEAD_BEEF, 17, 16);
`endif
        do_txn("rd_s1_noise", 1'b0, 32'hFFFF_F020, 32'h0, 1, 2, 4, 32'h1111_0001,
               1'b0, 32'h1111_0001, 4, 3);

        // Reset in the second ISSUE cycle of a transaction slave 2 never acks.
        @(negedge cpu_clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hFFFF_F040; cpu_wdata = 32'h7777_0007;
        @(negedge cpu_clk);
        cpu_req = 1'b0;
        check("mid_req_up", 32'(slv_req), 32'h4);
        @(negedge cpu_clk);
        cpu_rst = 1'b1;
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        check("mid_rst_slv_req", 32'(slv_req), 32'd0);
        check("mid_rst_busy",    32'(cpu_busy), 32'd0);
        check("mid_rst_ack",     32'(cpu_ack), 32'd0);
        check("mid_rst_rdata",   cpu_rdata, 32'd0);
        check("mid_rst_wdata",   slv_wdata, 32'd0);
        check("mid_rst_we",      32'(slv_we), 32'd0);
        repeat (3) @(negedge cpu_clk);
        do_txn("rd_after_rst", 1'b0, 32'h0000_1000, 32'h0, 0, 0, -1, 32'h0BAD_F00D,
               1'b0, 32'h0BAD_F00D, 2, 1);

        repeat (3) @(negedge cpu_clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
